// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU-op encoding,
// immediate formats, control bundle and the ID/EX register layout.
package pipeline_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // IMM_NONE covers R-type and illegal encodings (immediate driven as 0)
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef struct packed {
    imm_type_e  imm_type;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       rs1_used;
    logic       rs2_used;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        illegal;
  } idex_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_e t);
    case (t)
      IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   gen_imm = {i[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: gen_imm = '0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// 32x32 register file: two async read ports, one sync write port, x0 hardwired 0.
// `PSRV_RF_BYPASS_EN` makes reads write-through against the same-cycle writeback.
module pipeline_regfile (
  input  logic        clk_i,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] mem [32];

  // contents are deliberately left unreset
  always_ff @(posedge clk_i)
    if (we && waddr != 5'd0) mem[waddr] <= wdata;

  function automatic logic [31:0] rd_port(input logic [4:0] a, input logic [31:0] stored);
    if (a == 5'd0) rd_port = '0;
`ifdef PSRV_RF_BYPASS_EN
    else if (we && waddr == a) rd_port = wdata;
`endif
    else rd_port = stored;
  endfunction

  assign rdata1 = rd_port(raddr1, mem[raddr1]);
  assign rdata2 = rd_port(raddr2, mem[raddr2]);

endmodule

// File: rtl/pipeline_decode.sv
// RV32I decode stage: IF/ID register, regfile, immediates, control, load-use stall, ID/EX.
// Register-file write-through is selected by `PSRV_RF_BYPASS_EN` (see pipeline_regfile).
module pipeline_decode #(
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        flush_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_pc_plus4_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs1_o,
  output logic [4:0]  ex_rs2_o,
  output logic [4:0]  ex_rd_o,
  output logic [2:0]  ex_funct3_o,
  output logic        ex_funct7b5_o,
  output logic [1:0]  ex_alu_op_o,
  output logic        ex_alu_src_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write_o,
  output logic        ex_reg_write_o,
  output logic        ex_mem_to_reg_o,
  output logic        ex_branch_o,
  output logic        ex_jump_o,
  output logic        ex_illegal_o
);
  import pipeline_pkg::*;

  logic [31:0] if_instr, if_pc, if_pc4;
  logic        if_vld;
  ctrl_t       ctl;
  idex_t       ex_d, ex_q;
  logic [31:0] rdata1, rdata2;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opc;

  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      if_pc4   <= '0;
      if_vld   <= 1'b0;
    end else if (flush_i) begin
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      if_pc4   <= '0;
      if_vld   <= 1'b0;
    end else if (!stall_o) begin
      if_instr <= instruction_i;
      if_pc    <= pc_i;
      if_pc4   <= pc_plus4_i;
      if_vld   <= 1'b1;
    end

  assign opc = if_instr[6:0];
  assign rd  = if_instr[11:7];
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];

  always_comb begin
    ctl = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        ctl.imm_type = IMM_U; ctl.alu_src = 1'b1; ctl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctl.imm_type = IMM_J; ctl.jump = 1'b1; ctl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctl.imm_type = IMM_I; ctl.jump = 1'b1; ctl.alu_src = 1'b1;
        ctl.reg_write = 1'b1; ctl.rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        ctl.imm_type = IMM_B; ctl.branch = 1'b1; ctl.alu_op = ALU_BR;
        ctl.rs1_used = 1'b1; ctl.rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        ctl.imm_type = IMM_I; ctl.mem_read = 1'b1; ctl.mem_to_reg = 1'b1;
        ctl.alu_src = 1'b1; ctl.reg_write = 1'b1; ctl.rs1_used = 1'b1;
      end
      OPC_STORE: begin
        ctl.imm_type = IMM_S; ctl.mem_write = 1'b1; ctl.alu_src = 1'b1;
        ctl.rs1_used = 1'b1; ctl.rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        ctl.imm_type = IMM_I; ctl.alu_op = ALU_I; ctl.alu_src = 1'b1;
        ctl.reg_write = 1'b1; ctl.rs1_used = 1'b1;
      end
      OPC_OP: begin
        ctl.alu_op = ALU_R; ctl.reg_write = 1'b1;
        ctl.rs1_used = 1'b1; ctl.rs2_used = 1'b1;
      end
      default: ctl.illegal = 1'b1;
    endcase
  end

  pipeline_regfile u_rf (
    .clk_i  (clk_i),
    .we     (wb_en_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // flush overrides the stall so a wrong-path consumer never holds fetch
  assign stall_o = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                   ((ctl.rs1_used & (ex_q.rd == rs1)) | (ctl.rs2_used & (ex_q.rd == rs2))) &
                   ~flush_i;

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = 1'b1;
    ex_d.pc         = if_pc;
    ex_d.pc_plus4   = if_pc4;
    ex_d.rs1_data   = rdata1;
    ex_d.rs2_data   = rdata2;
    ex_d.imm        = gen_imm(if_instr, ctl.imm_type);
    ex_d.rs1        = rs1;
    ex_d.rs2        = rs2;
    ex_d.rd         = rd;
    ex_d.funct3     = if_instr[14:12];
    ex_d.funct7b5   = if_instr[30];
    ex_d.alu_op     = ctl.alu_op;
    ex_d.alu_src    = ctl.alu_src;
    ex_d.mem_read   = ctl.mem_read;
    ex_d.mem_write  = ctl.mem_write;
    ex_d.reg_write  = ctl.reg_write;
    ex_d.mem_to_reg = ctl.mem_to_reg;
    ex_d.branch     = ctl.branch;
    ex_d.jump       = ctl.jump;
    ex_d.illegal    = ctl.illegal;
  end

  // an invalid IF/ID (post-reset/flush NOP) also enters EX as an all-zero bubble
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i)                            ex_q <= '0;
    else if (flush_i || stall_o || !if_vld)  ex_q <= '0;
    else                                     ex_q <= ex_d;

  assign ex_valid_o      = ex_q.valid;
  assign ex_pc_o         = ex_q.pc;
  assign ex_pc_plus4_o   = ex_q.pc_plus4;
  assign ex_rs1_data_o   = ex_q.rs1_data;
  assign ex_rs2_data_o   = ex_q.rs2_data;
  assign ex_imm_o        = ex_q.imm;
  assign ex_rs1_o        = ex_q.rs1;
  assign ex_rs2_o        = ex_q.rs2;
  assign ex_rd_o         = ex_q.rd;
  assign ex_funct3_o     = ex_q.funct3;
  assign ex_funct7b5_o   = ex_q.funct7b5;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_illegal_o    = ex_q.illegal;

endmodule

// File: tb/tb_pipeline_decode.sv
// Scoreboard bench for pipeline_decode: expected ID/EX contents are queued with
// the cycle they are due and compared when that cycle's edge has passed.
module tb_pipeline_decode;

  logic        clk_i = 1'b0, reset_i;
  logic [31:0] instruction_i, pc_i, pc_plus4_i, wb_data_i;
  logic        flush_i, wb_en_i;
  logic [4:0]  wb_rd_i;
  logic        stall_o, ex_valid_o, ex_funct7b5_o, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o;
  logic        ex_reg_write_o, ex_mem_to_reg_o, ex_branch_o, ex_jump_o, ex_illegal_o;
  logic [31:0] ex_pc_o, ex_pc_plus4_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [1:0]  ex_alu_op_o;

  pipeline_decode dut (
    .clk_i(clk_i), .reset_i(reset_i), .instruction_i(instruction_i), .pc_i(pc_i),
    .pc_plus4_i(pc_plus4_i), .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .ex_pc_plus4_o(ex_pc_plus4_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_branch_o(ex_branch_o),
    .ex_jump_o(ex_jump_o), .ex_illegal_o(ex_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [7:0] C_ASRC = 8'h80, C_MRD = 8'h40, C_MWR = 8'h20, C_RW = 8'h10;
  localparam logic [7:0] C_M2R  = 8'h08, C_BR  = 8'h04, C_J   = 8'h02, C_ILL = 8'h01;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef PSRV_RF_BYPASS_EN
  localparam logic [31:0] X9_SAME_CYCLE = 32'h1234_5678;
`else
  localparam logic [31:0] X9_SAME_CYCLE = 32'hAAAA_0000;
`endif

  typedef struct packed {
    logic [31:0] due;
    logic        vld;
    logic [31:0] pc, pc4, imm, d1, d2;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [1:0]  aop;
    logic [7:0]  ctl;
    logic        ci, c1, c2;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [1:0] aop, input logic [7:0] ctl, input logic ci,
                              input logic [31:0] d1, input logic c1, input logic [31:0] d2,
                              input logic c2);
    exp_t e;
    e = '0;
    e.vld = 1'b1; e.pc = pc; e.pc4 = pc + 32'd4; e.imm = imm; e.aop = aop; e.ctl = ctl;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12]; e.f7 = ins[30];
    e.ci = ci; e.d1 = d1; e.c1 = c1; e.d2 = d2; e.c2 = c2;
    return e;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    e.ci = 1'b1; e.c1 = 1'b1; e.c2 = 1'b1;
    return e;
  endfunction

  task automatic push(input exp_t e, input int lat);
    e.due = cyc + lat;
    q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("ex_valid", {31'b0, ex_valid_o}, {31'b0, e.vld});
      chk("ex_pc", ex_pc_o, e.pc);
      chk("ex_pc4", ex_pc_plus4_o, e.pc4);
      chk("ex_idx", {17'b0, ex_rd_o, ex_rs1_o, ex_rs2_o}, {17'b0, e.rd, e.rs1, e.rs2});
      chk("ex_f3f7", {28'b0, ex_funct3_o, ex_funct7b5_o}, {28'b0, e.f3, e.f7});
      chk("ex_alu_op", {30'b0, ex_alu_op_o}, {30'b0, e.aop});
      chk("ex_ctl", {24'b0, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o,
                     ex_mem_to_reg_o, ex_branch_o, ex_jump_o, ex_illegal_o}, {24'b0, e.ctl});
      if (e.ci) chk("ex_imm", ex_imm_o, e.imm);
      if (e.c1) chk("ex_rs1_data", ex_rs1_data_o, e.d1);
      if (e.c2) chk("ex_rs2_data", ex_rs2_data_o, e.d2);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd);
    instruction_i = ins; pc_i = pc; pc_plus4_i = pc + 32'd4; flush_i = fl;
    wb_en_i = we; wb_rd_i = wr; wb_data_i = wd;
    @(posedge clk_i); #1;
    cyc++;
    sb_check();
  endtask

  task automatic nop();
    step(NOP, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic ins(input logic [31:0] i, input logic [31:0] pc);
    step(i, pc, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset_i = 1'b0; instruction_i = 32'hFFF08293; pc_i = 32'h40; pc_plus4_i = 32'h44;
    flush_i = 1'b0; wb_en_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
    #1;
    chk("rst_valid", {31'b0, ex_valid_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_imm", ex_imm_o, 32'h0);
    chk("rst_pc", ex_pc_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #2 reset_i = 1'b1;
    chk("rst_hold_valid", {31'b0, ex_valid_o}, 32'h0);

    // preload registers; x0 write must be ignored
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd1, 32'h0000_0011);
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd2, 32'h0000_1000);
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd3, 32'h0000_0033);
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd9, 32'hAAAA_0000);
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    nop();

    // decode / immediate sweep
    push(mk(32'hFFF08293, 32'h100, 32'hFFFF_FFFF, 2'b11, C_ASRC | C_RW, 1, 32'h11, 1, 0, 0), 2);
    ins(32'hFFF08293, 32'h100);
    push(mk(32'hFFDFF0EF, 32'h104, 32'hFFFF_FFFC, 2'b00, C_J | C_RW, 1, 0, 0, 0, 0), 2);
    ins(32'hFFDFF0EF, 32'h104);
    push(mk(32'hFE512C23, 32'h108, 32'hFFFF_FFF8, 2'b00, C_ASRC | C_MWR, 1, 32'h1000, 1, 0, 0), 2);
    ins(32'hFE512C23, 32'h108);
    push(mk(32'h12345537, 32'h10C, 32'h1234_5000, 2'b00, C_ASRC | C_RW, 1, 0, 0, 0, 0), 2);
    ins(32'h12345537, 32'h10C);
    push(mk(32'h00308463, 32'h110, 32'h0000_0008, 2'b01, C_BR, 1, 32'h11, 1, 32'h33, 1), 2);
    ins(32'h00308463, 32'h110);
    push(mk(32'h0000007F, 32'h114, 32'h0, 2'b00, C_ILL, 0, 0, 0, 0, 0), 2);
    ins(32'h0000007F, 32'h114);

    // load-use: lw x6,0(x2) ; add x7,x6,x3
    push(mk(32'h00012303, 32'h200, 32'h0, 2'b00, C_ASRC | C_MRD | C_RW | C_M2R, 1, 32'h1000, 1, 0, 0), 2);
    ins(32'h00012303, 32'h200);
    push(bubble(), 2);
    push(mk(32'h003303B3, 32'h204, 32'h0, 2'b10, C_RW, 1, 0, 0, 32'h33, 1), 3);
    ins(32'h003303B3, 32'h204);
    chk("lu_stall", {31'b0, stall_o}, 32'h1);
    ins(32'h003303B3, 32'h204);
    chk("lu_release", {31'b0, stall_o}, 32'h0);
    nop();
    nop();

    // load to x0 never stalls; x0 reads 0 despite the DEADBEEF write
    push(mk(32'h00012003, 32'h300, 32'h0, 2'b00, C_ASRC | C_MRD | C_RW | C_M2R, 1, 32'h1000, 1, 0, 0), 2);
    ins(32'h00012003, 32'h300);
    push(mk(32'h000003B3, 32'h304, 32'h0, 2'b10, C_RW, 1, 32'h0, 1, 32'h0, 1), 2);
    ins(32'h000003B3, 32'h304);
    chk("x0_nostall", {31'b0, stall_o}, 32'h0);

    // flush: OP in IF/ID and OP on fetch both discarded
    push(bubble(), 2);
    ins(32'h003083B3, 32'h400);
    push(bubble(), 2);
    step(32'h003083B3, 32'h404, 1'b1, 1'b0, 5'd0, 32'h0);
    nop();
    nop();

    // flush during a load-use stall
    push(mk(32'h00012303, 32'h500, 32'h0, 2'b00, C_ASRC | C_MRD | C_RW | C_M2R, 1, 32'h1000, 1, 0, 0), 2);
    ins(32'h00012303, 32'h500);
    push(bubble(), 2);
    push(bubble(), 3);
    ins(32'h003303B3, 32'h504);
    chk("fs_stall_pre", {31'b0, stall_o}, 32'h1);
    flush_i = 1'b1;
    #1 chk("fs_stall_drop", {31'b0, stall_o}, 32'h0);
    step(32'h003303B3, 32'h504, 1'b1, 1'b0, 5'd0, 32'h0);
    nop();
    nop();

    // same-cycle writeback of x9 while add x1,x9,x9 is decoded
    push(mk(32'h009480B3, 32'h600, 32'h0, 2'b10, C_RW, 1, X9_SAME_CYCLE, 1, X9_SAME_CYCLE, 1), 2);
    ins(32'h009480B3, 32'h600);
    step(NOP, 32'h0, 1'b0, 1'b1, 5'd9, 32'h1234_5678);
    push(mk(32'h009480B3, 32'h604, 32'h0, 2'b10, C_RW, 1, 32'h1234_5678, 1, 32'h1234_5678, 1), 2);
    ins(32'h009480B3, 32'h604);
    nop();
    nop();

    // async reset while stalled
    push(mk(32'h00012303, 32'h700, 32'h0, 2'b00, C_ASRC | C_MRD | C_RW | C_M2R, 1, 32'h1000, 1, 0, 0), 2);
    ins(32'h00012303, 32'h700);
    ins(32'h003303B3, 32'h704);
    chk("ar_stall_pre", {31'b0, stall_o}, 32'h1);
    #2 reset_i = 1'b0;
    #1;
    chk("ar_stall", {31'b0, stall_o}, 32'h0);
    chk("ar_valid", {31'b0, ex_valid_o}, 32'h0);
    chk("ar_ctl", {27'b0, ex_mem_read_o, ex_reg_write_o, ex_alu_src_o, ex_mem_to_reg_o, ex_jump_o}, 32'h0);
    chk("ar_rd", {27'b0, ex_rd_o}, 32'h0);
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    push(mk(32'hFFF08293, 32'h800, 32'hFFFF_FFFF, 2'b11, C_ASRC | C_RW, 1, 32'h11, 1, 0, 0), 2);
    ins(32'hFFF08293, 32'h800);
    chk("ar_first_edge", {31'b0, ex_valid_o}, 32'h0);
    nop();
    nop();

    chk("sb_empty", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
